irq_controller: RTL
===================

// Module: irq_controller
// PURPOSE
//  Parametrised multi-line interrupt controller: successor to the single interrupt_signal input.
//  Latches rising edges on N_IRQ lines, applies a mask and fixed priority, and raises one
//  request to fetch with a vector address. Sits between the external IRQ pins and fetch/decode.
//  Tracks the in-service interrupt until the RTI instruction retires.
// PARAMETERS
//  N_IRQ       4          number of interrupt lines; index 0 = highest priority
//  PC_WIDTH    32         width of the vector address
//  VEC_BASE    32'h2      vector address of IRQ 0
//  VEC_STRIDE  1          address distance between consecutive vectors
//  NEST_DEPTH  2          in-service stack depth (used only with IRQ_NESTING_EN)
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            asynchronous, active-low reset
//  irq_in        in   N_IRQ        interrupt lines, synchronous to clk
//  mask_we       in   1            write enable for mask register
//  mask_wdata    in   N_IRQ        new mask; 1 = line disabled
//  pipe_ready    in   1            pipeline is at an instruction boundary; request may be taken
//  int_ack       in   1            fetch has loaded int_vec_addr and saved the PC
//  rti_done      in   1            RTI instruction retired
//  int_req       out  1            interrupt request to fetch
//  int_vec_addr  out  PC_WIDTH     VEC_BASE + int_id*VEC_STRIDE
//  int_id        out  $clog2(N_IRQ)  ID being requested or in service
//  pending       out  N_IRQ        pending register
//  mask          out  N_IRQ        mask register
//  busy          out  1            state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending=0, mask=0, edge history=0, stack empty.
//  Edge detect: pending[i] set when irq_in[i]=1 and last cycle's irq_in[i]=0.
//   Set on cycle t+1 after an edge at cycle t. Masked lines still latch pending.
//  Clear: pending[int_id] cleared on the int_ack cycle.
//   A new edge on the same line in that cycle wins, so the bit stays 1.
//  mask: written on mask_we, visible the next cycle.
//  Eligible set: pending & ~mask. Winner: lowest index in the eligible set.
//  FSM, per cycle:
//   IDLE:    eligible!=0 && pipe_ready -> REQ; int_id/int_vec_addr latch the winner.
//   REQ:     int_req=1; int_id/vector frozen, no re-arbitration.
//            A mask write or new edge does not cancel the request.
//            int_ack -> SERVICE; int_req deasserts the cycle after the ack.
//   SERVICE: rti_done -> IDLE, or pop (see CONFIGURATION). int_id keeps the in-service ID.
//  Latency: edge at t, pipe_ready high -> int_req=1 at t+2.
//  int_ack outside REQ is ignored. rti_done outside SERVICE is ignored.
//  int_ack and rti_done in the same cycle: state decides which one is acted on.
//  rst low mid-operation: immediate return to reset values; the in-flight request is dropped.
//  Vector arithmetic: PC_WIDTH bits, modulo 2^PC_WIDTH.
// CONFIGURATION
//  IRQ_NESTING_EN defined:
//   In SERVICE, an eligible winner with index < int_id, plus pipe_ready, plus stack not full:
//    - push int_id onto the stack;
//    - go to REQ with the new winner.
//   rti_done with stack non-empty: pop into int_id and stay in SERVICE.
//   rti_done with stack empty: go to IDLE.
//   Stack full: no preemption; the request waits.
//  IRQ_NESTING_EN undefined:
//   No stack logic and NEST_DEPTH is unused.
//   SERVICE ignores new interrupts until rti_done.
// TESTING
//  1) Edge on irq_in[2], mask=0, pipe_ready=1 -> int_req at t+2.
//     int_id=2, int_vec_addr=32'h4. Ack -> pending[2]=0, SERVICE. rti_done -> IDLE.
//  2) Edges on irq 1 and 3 in the same cycle -> irq 1 serviced first.
//     After its rti_done, irq 3 is requested with vector 32'h5.
//  3) mask=4'b0001, edge on irq 0 -> pending[0]=1 and no int_req.
//     Write mask=0 -> int_req two cycles later.
//  4) pipe_ready=0 for 5 cycles with irq pending -> int_req stays 0.
//     Request is raised the cycle after pipe_ready rises.
//  5) Edge on irq 1 during the ack of irq 1 -> pending[1] stays 1 and is re-requested after rti.
//     Drop rst while in REQ -> int_req, busy, pending all 0 immediately.
//  6) [IRQ_NESTING_EN] Servicing irq 3, edge on irq 0 -> preempt, stack holds 3.
//     rti_done -> int_id=3, still SERVICE. Second rti_done -> IDLE.

Source files
------------

// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt controller and its environment (pins, CSR write, fetch).
// The controller takes the slave modport; whoever drives the pins and fetch handshake takes master.
interface irq_controller_if #(
    parameter int N_IRQ    = 4,
    parameter int PC_WIDTH = 32
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0]    irq_in;
    logic                mask_we;
    logic [N_IRQ-1:0]    mask_wdata;
    logic                pipe_ready;
    logic                int_ack;
    logic                rti_done;
    logic                int_req;
    logic [PC_WIDTH-1:0] int_vec_addr;
    logic [ID_W-1:0]     int_id;
    logic [N_IRQ-1:0]    pending;
    logic [N_IRQ-1:0]    mask;
    logic                busy;

    modport master (
        output irq_in, mask_we, mask_wdata, pipe_ready, int_ack, rti_done,
        input  int_req, int_vec_addr, int_id, pending, mask, busy
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, pipe_ready, int_ack, rti_done,
        output int_req, int_vec_addr, int_id, pending, mask, busy
    );
endinterface

// File: rtl/irq_controller.sv
// Multi-line interrupt controller: edge latch, mask, fixed priority (index 0 highest), vectoring.
// Define IRQ_NESTING_EN to allow higher-priority preemption through an in-service ID stack.
module irq_controller #(
    parameter int                  N_IRQ      = 4,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] VEC_BASE   = 32'h2,
    parameter int                  VEC_STRIDE = 1,
    parameter int                  NEST_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    irq_controller_if.slave bus
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t              state_q, state_d;
    logic [N_IRQ-1:0]    irq_q, pending_q, pending_d, mask_q, elig, clr_vec;
    logic [ID_W-1:0]     id_q, id_d, win_id;
    logic [PC_WIDTH-1:0] vec_q;
    logic                any_win, load_id;

    function automatic logic [PC_WIDTH-1:0] vec_of(input logic [ID_W-1:0] id);
        return VEC_BASE + PC_WIDTH'(id) * PC_WIDTH'(VEC_STRIDE);
    endfunction

    // A fresh edge in the ack cycle must survive the clear, so set is applied last.
    always_comb begin
        clr_vec   = (state_q == REQ && bus.int_ack) ? (N_IRQ'(1) << id_q) : '0;
        pending_d = (pending_q & ~clr_vec) | (bus.irq_in & ~irq_q);
        elig      = pending_q & ~mask_q;
        any_win   = |elig;
        win_id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) win_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            irq_q     <= bus.irq_in;
            pending_q <= pending_d;
            if (bus.mask_we) mask_q <= bus.mask_wdata;
        end
    end

`ifdef IRQ_NESTING_EN
    localparam int SP_W = $clog2(NEST_DEPTH + 1);

    logic [NEST_DEPTH-1:0][ID_W-1:0] stack_q;
    logic [SP_W-1:0]                 sp_q;
    logic [ID_W-1:0]                 stack_top;
    logic                            push, pop, stack_full;

    always_comb begin
        stack_full = (sp_q == SP_W'(NEST_DEPTH));
        stack_top  = '0;
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (SP_W'(k + 1) == sp_q) stack_top = stack_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stack_q <= '0;
            sp_q    <= '0;
        end else if (push) begin
            for (int k = 0; k < NEST_DEPTH; k++) begin
                if (SP_W'(k) == sp_q) stack_q[k] <= id_q;
            end
            sp_q <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        load_id = 1'b0;
        id_d    = win_id;
`ifdef IRQ_NESTING_EN
        push    = 1'b0;
        pop     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_win && bus.pipe_ready) begin
                    state_d = REQ;
                    load_id = 1'b1;
                end
            end
            REQ: begin
                if (bus.int_ack) state_d = SERVICE;
            end
            SERVICE: begin
`ifdef IRQ_NESTING_EN
                // Retirement takes precedence over a preemption arriving in the same cycle.
                if (bus.rti_done) begin
                    if (sp_q != '0) begin
                        pop     = 1'b1;
                        load_id = 1'b1;
                        id_d    = stack_top;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (any_win && (win_id < id_q) && bus.pipe_ready && !stack_full) begin
                    push    = 1'b1;
                    load_id = 1'b1;
                    state_d = REQ;
                end
`else
                if (bus.rti_done) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_id) begin
                id_q  <= id_d;
                vec_q <= vec_of(id_d);
            end
        end
    end

    assign bus.int_req      = (state_q == REQ);
    assign bus.busy         = (state_q != IDLE);
    assign bus.int_id       = id_q;
    assign bus.int_vec_addr = vec_q;
    assign bus.pending      = pending_q;
    assign bus.mask         = mask_q;
endmodule
